// File: rtl/ipm_rng_pkg.sv
// Purpose: shared types, constants and the byte-wide LFSR step for ipm_rng.
// Latency: combinational helper; no state lives here.
// Backpressure: n/a.
// Contents: IPM_RNG_POLY, IPM_RNG_SEED_DEFAULT, ipm_rng_state_e, ipm_rng_step8().
package ipm_rng_pkg;

  // x^32 + x^22 + x^2 + x + 1, Galois form (right shift, xor on carry-out)
  localparam logic [31:0] IPM_RNG_POLY         = 32'h8020_0003;
  localparam logic [31:0] IPM_RNG_SEED_DEFAULT = 32'hACE1_2024;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    RESEED = 2'd2
  } ipm_rng_state_e;

  typedef struct packed {
    logic [31:0] state;
    logic [7:0]  data;
  } ipm_rng_step_t;

  // Eight LFSR steps; step 1 output lands in data[0], step 8 in data[7].
  function automatic ipm_rng_step_t ipm_rng_step8(input logic [31:0] s);
    ipm_rng_step_t r;
    logic [31:0]   x;
    logic          o;
    x      = s;
    r.data = '0;
    for (int i = 0; i < 8; i++) begin
      o         = x[0];
      r.data[i] = o;
      x         = x >> 1;
      if (o) x = x ^ IPM_RNG_POLY;
    end
    r.state = x;
    return r;
  endfunction

endpackage

// File: rtl/ipm_rng_if.sv
// Purpose: randomness word stream from ipm_rng to the IPM consumer.
// Latency: wires only.
// Backpressure: consumer holds rnd_ready_i low; producer keeps rnd_o stable.
// Signals: rnd_valid_o, rnd_o[31:0], level_o (producer); rnd_ready_i (consumer).
interface ipm_rng_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     rnd_valid_o;
  logic                     rnd_ready_i;
  logic [31:0]              rnd_o;
  logic [$clog2(DEPTH):0]   level_o;

  modport master (output rnd_valid_o, output rnd_o, output level_o, input rnd_ready_i);
  modport slave  (input rnd_valid_o, input rnd_o, input level_o, output rnd_ready_i);
endinterface

// File: rtl/ipm_rng_fifo.sv
// Purpose: small synchronous word FIFO with flush and occupancy count.
// Latency: push visible at head one cycle after the write edge; head is combinational.
// Backpressure: push is dropped when full unless a pop frees the slot on the same edge.
// Ports: clk_i, reset_ni, flush_i, push_i/push_dat_i, pop_i, vld_o, head_o, level_o.
module ipm_rng_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic                   vld_o,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             empty, full, do_pop, do_push;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // Power-of-two depth: pointers wrap modulo DEPTH by natural overflow.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign vld_o   = !empty;
  // Storage is not reset, so mask the head to zero while empty.
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ipm_rng.sv
// Purpose: masking-randomness source; LFSR bytes packed four per word into a FIFO.
// Latency: first word written on the 4th generating edge after reset/reseed, then 1 word / 4 cycles.
// Backpressure: full FIFO without a pop stalls LFSR and packer; nothing is dropped.
// Ports: clk_i, reset_ni, en_i, seed_i, seed_valid_i, rnd_if (master: rnd_valid_o, rnd_o, level_o, rnd_ready_i).
module ipm_rng
  import ipm_rng_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          NONZERO      = 1'b1,
  parameter logic [31:0] SEED_DEFAULT = IPM_RNG_SEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  input  logic        seed_valid_i,
  ipm_rng_if.master   rnd_if
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] ALMST_LVL = LW'(DEPTH - 1);

  ipm_rng_state_e state_q, state_d;
  logic [31:0]    lfsr_q;
  logic [23:0]    pack_q;
  logic [1:0]     cnt_q;
  ipm_rng_step_t  step;
  logic           pop, full, gen, byte_ok, accept, wr;
  logic           fifo_vld;
  logic [31:0]    fifo_head;
  logic [LW-1:0]  level;

  assign pop     = fifo_vld && rnd_if.rnd_ready_i;
  assign full    = (level == FULL_LVL);
  assign step    = ipm_rng_step8(lfsr_q);
  // A pop on a full FIFO frees the slot the 4th byte would need, so keep going.
  assign gen     = en_i && (state_q == RUN) && !(full && !pop);
  assign byte_ok = !NONZERO || (step.data != 8'h00);
  assign accept  = gen && byte_ok;
  assign wr      = accept && (cnt_q == 2'd3) && !seed_valid_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (!pop && (full || (wr && level == ALMST_LVL))) state_d = STALL;
      STALL:   if (pop) state_d = RUN;
      RESEED:  state_d = RUN;
      default: state_d = RUN;
    endcase
    if (seed_valid_i) state_d = RESEED;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= RUN;
    else           state_q <= state_d;
  end

  // Reseed outranks generation; an all-zero seed would lock the LFSR at zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lfsr_q <= SEED_DEFAULT;
      pack_q <= '0;
      cnt_q  <= '0;
    end else if (seed_valid_i) begin
      lfsr_q <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
      pack_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (gen) lfsr_q <= step.state;
      if (accept) begin
        case (cnt_q)
          2'd0:    pack_q[23:16] <= step.data;
          2'd1:    pack_q[15:8]  <= step.data;
          2'd2:    pack_q[7:0]   <= step.data;
          default: pack_q        <= pack_q;
        endcase
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  ipm_rng_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .flush_i   (seed_valid_i),
    .push_i    (wr),
    .push_dat_i({pack_q, step.data}),
    .pop_i     (pop),
    .vld_o     (fifo_vld),
    .head_o    (fifo_head),
    .level_o   (level)
  );

  assign rnd_if.rnd_valid_o = fifo_vld;
  assign rnd_if.rnd_o       = fifo_head;
  assign rnd_if.level_o     = level;

endmodule

// File: tb/tb_ipm_rng.sv
// Purpose: randomized scoreboard bench for ipm_rng against a queue-based reference model.
// Latency: model steps on each rising edge; monitor checks 8 time units later.
// Backpressure: consumer ready randomized, plus directed full/stall and reseed-with-pop cases.
module tb_ipm_rng;
  import ipm_rng_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] SEED_DEF = 32'hACE1_2024;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [31:0] seed_i = '0;
  logic        seed_valid_i = 1'b0;
  logic        rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  ipm_rng_if #(.DEPTH(DEPTH)) rif ();
  assign rif.rnd_ready_i = rdy;

  ipm_rng #(
    .DEPTH(DEPTH),
    .NONZERO(1'b1),
    .SEED_DEFAULT(SEED_DEF)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .en_i        (en_i),
    .seed_i      (seed_i),
    .seed_valid_i(seed_valid_i),
    .rnd_if      (rif)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_lfsr;
  logic [7:0]  m_pack[$];
  logic [31:0] sb_q[$];      // words the DUT should still deliver, oldest first
  int          m_level;
  bit          m_stalled, m_reseed;
  int          zero_cnt;

  // 8 bit-serial steps of the Galois register; returns {byte, next_state}.
  function automatic logic [39:0] ref_byte(input logic [31:0] s);
    logic [7:0] b;
    bit         o;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      o    = s[0];
      b[i] = o;
      s    = s >> 1;
      if (o) s = s ^ POLY;
    end
    return {b, s};
  endfunction

  function automatic logic [31:0] ref_first_word(input logic [31:0] s);
    logic [39:0] r;
    logic [31:0] w;
    int          n;
    w = '0;
    n = 0;
    while (n < 4) begin
      r = ref_byte(s);
      s = r[31:0];
      if (r[39:32] != 8'h00) begin
        w = {w[23:0], r[39:32]};
        n++;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED_DEF;
    m_pack.delete();
    sb_q.delete();
    m_level   = 0;
    m_stalled = 0;
    m_reseed  = 0;
  endtask

  // The monitor has already taken any popped word out of sb_q by this edge.
  task automatic model_step();
    bit          pop, gen;
    logic [39:0] r;
    pop = (m_level > 0) && rdy;
    if (seed_valid_i) begin
      m_lfsr = (seed_i == 0) ? SEED_DEF : seed_i;
      m_pack.delete();
      sb_q.delete();
      m_level   = 0;
      m_stalled = 0;
      m_reseed  = 1;
      return;
    end
    gen      = en_i && !m_stalled && !m_reseed && !(m_level == DEPTH && !pop);
    m_reseed = 0;
    if (pop) m_level--;
    if (gen) begin
      r      = ref_byte(m_lfsr);
      m_lfsr = r[31:0];
      if (r[39:32] == 8'h00) zero_cnt++;
      else begin
        m_pack.push_back(r[39:32]);
        if (m_pack.size() == 4) begin
          sb_q.push_back({m_pack[0], m_pack[1], m_pack[2], m_pack[3]});
          m_level++;
          m_pack.delete();
        end
      end
    end
    m_stalled = (m_level == DEPTH) && !pop;
  endtask

  always @(posedge clk_i) begin
    if (!reset_ni) model_reset();
    else           model_step();
  end

  // ---------------- monitor ----------------
  always begin
    @(posedge clk_i);
    #8;
    if (!reset_ni) begin
      chk("rst_valid", 32'(rif.rnd_valid_o), 32'd0);
      chk("rst_level", 32'(rif.level_o), 32'd0);
      chk("rst_rnd", rif.rnd_o, 32'd0);
    end else begin
      chk("level", 32'(rif.level_o), 32'(m_level));
      chk("valid", 32'(rif.rnd_valid_o), 32'(m_level > 0));
      chk("lfsr", dut.lfsr_q, m_lfsr);
      if (rif.rnd_valid_o && rdy) begin
        if (sb_q.size() == 0) chk("pop_no_expected_word", 32'd1, 32'd0);
        else                  chk("word", rif.rnd_o, sb_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic reseed(input logic [31:0] s);
    seed_i       = s;
    seed_valid_i = 1'b1;
    tick();
    seed_valid_i = 1'b0;
  endtask

  task automatic wait_level(input int lvl, input string nm);
    int k;
    k = 0;
    while (int'(rif.level_o) != lvl && k < 60) begin
      tick();
      k++;
    end
    chk(nm, 32'(rif.level_o), 32'(lvl));
  endtask

  task automatic rand_phase(input int n, input int rdy_pct, input bit do_rst);
    for (int i = 0; i < n; i++) begin
      en_i         = ($urandom_range(0, 9) < 8);
      rdy          = ($urandom_range(0, 99) < rdy_pct);
      seed_valid_i = ($urandom_range(0, 99) < 2);
      seed_i       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      if (do_rst && i == n / 2) reset_ni = 1'b0;
      tick();
      reset_ni = 1'b1;
    end
    seed_valid_i = 1'b0;
  endtask

  initial begin
    zero_cnt = 0;
    model_reset();
    reset_ni = 1'b0;
    tick();
    tick();
    reset_ni = 1'b1;
    chk("reset_state_run", 32'(dut.state_q), 32'(RUN));

    rand_phase(300, 50, 1'b0);

    // Reseed with 1: first byte 0xDB, LFSR after byte 1 = 0xDB36C002.
    rdy  = 1'b0;
    en_i = 1'b1;
    reseed(32'h0000_0001);      // reseed edge done; RESEED cycle now
    tick();                     // RESEED -> RUN, no generation
    tick();                     // first generating edge
    chk("lfsr_after_byte1", dut.lfsr_q, 32'hDB36_C002);
    wait_level(1, "first_word_arrives");
    chk("first_word_lane3", 32'(rif.rnd_o[31:24]), 32'h0000_00DB);

    // Fill until stalled, then one pop and refill.
    wait_level(DEPTH, "fill_to_depth");
    tick();
    chk("stall_state", 32'(dut.state_q), 32'(STALL));
    tick();
    tick();
    chk("stall_level_held", 32'(rif.level_o), 32'(DEPTH));
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("level_after_pop", 32'(rif.level_o), 32'(DEPTH - 1));
    wait_level(DEPTH, "refill_to_depth");

    // Reseed with 0 behaves as the default seed.
    reseed(32'd0);
    wait_level(1, "seed0_first_word");
    chk("seed0_word", rif.rnd_o, ref_first_word(SEED_DEF));

    // Reseed coinciding with a pop at level 3.
    reseed($urandom() | 32'd1);
    wait_level(3, "reach_level3");
    seed_i       = $urandom();
    seed_valid_i = 1'b1;
    rdy          = 1'b1;
    tick();
    seed_valid_i = 1'b0;
    rdy          = 1'b0;
    #1;
    chk("seed_pop_valid_low", 32'(rif.rnd_valid_o), 32'd0);
    chk("seed_pop_level0", 32'(rif.level_o), 32'd0);

    // Continuous draining around full, then long mixed traffic.
    rdy  = 1'b1;
    en_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rdy = (i % 5) != 0;
      tick();
    end
    rand_phase(1500, 70, 1'b1);
    rand_phase(800, 20, 1'b0);

    chk("zero_bytes_dropped_seen", 32'(zero_cnt != 0), 32'd1);
    en_i = 1'b0;
    rdy  = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
